// File: rtl/regmux_merge2_pkg.sv
// Shared constants and grant helper for the two-lane RSA merge.
// Lane indices, default widths and the round-robin pick.
package regmux_merge2_pkg;

  localparam int RSA_DW_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef struct packed {
    logic vld;
    logic lane;
  } grant_t;

  // Round-robin pick: rr breaks the tie only when both lanes hold data.
  function automatic grant_t rr_pick(
    input logic ne0,
    input logic ne1,
    input logic rr
  );
    grant_t g;
    g = '{vld: 1'b0, lane: LANE0};
    unique case (1'b1)
      (ne0 && ne1):  g = '{vld: 1'b1, lane: rr};
      (ne0 && !ne1): g = '{vld: 1'b1, lane: LANE0};
      (!ne0 && ne1): g = '{vld: 1'b1, lane: LANE1};
      default:       g = '{vld: 1'b0, lane: LANE0};
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rsa_sync_fifo.sv
// Per-lane synchronous FIFO with show-ahead head word.
// Extra pointer MSB distinguishes full from empty.
module rsa_sync_fifo #(
  parameter int RSA_DW     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [RSA_DW-1:0] wr_data,
  input  logic              rd_en,
  output logic [RSA_DW-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [RSA_DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic              do_wr;
  logic              do_rd;

  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rp[AW-1:0]];

  // Pointer update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (sys_rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/regmux_merge2.sv
// Merges two RSA lane streams into one registered output.
// Fixed-lane or round-robin grant, source lane tagged.
module regmux_merge2
  import regmux_merge2_pkg::*;
#(
  parameter int RSA_DW     = RSA_DW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              mode,
  input  logic              sel,
  input  logic [RSA_DW-1:0] din_0,
  input  logic              din_0_valid,
  output logic              din_0_ready,
  input  logic [RSA_DW-1:0] din_1,
  input  logic              din_1_valid,
  output logic              din_1_ready,
  output logic [RSA_DW-1:0] dout,
  output logic              dout_src,
  output logic              dout_valid,
  input  logic              dout_ready
);

  logic              flush;
  logic              live;
  logic              full0;
  logic              full1;
  logic              empty0;
  logic              empty1;
  logic [RSA_DW-1:0] head0;
  logic [RSA_DW-1:0] head1;
  logic              push0;
  logic              push1;
  logic              pop0;
  logic              pop1;
  logic              load_ok;
  logic              load;
  logic              rr;
  grant_t            gnt;

  assign flush = !en;
  assign live  = en && !sys_rst;

  assign din_0_ready = live && !full0;
  assign din_1_ready = live && !full1;

  assign push0 = din_0_valid && din_0_ready;
  assign push1 = din_1_valid && din_1_ready;

  assign load_ok = !dout_valid || dout_ready;
  assign load    = live && load_ok && gnt.vld;

  assign pop0 = load && (gnt.lane == LANE0);
  assign pop1 = load && (gnt.lane == LANE1);

  // Grant: fixed lane in mode 0, alternating in mode 1.
  always_comb begin
    gnt = '{vld: 1'b0, lane: LANE0};
    if (!mode) begin
      gnt.lane = sel;
      gnt.vld  = sel ? !empty1 : !empty0;
    end else begin
      gnt = rr_pick(!empty0, !empty1, rr);
    end
  end

  rsa_sync_fifo #(
    .RSA_DW     (RSA_DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .sys_rst (sys_rst),
    .flush   (flush),
    .wr_en   (push0),
    .wr_data (din_0),
    .rd_en   (pop0),
    .rd_data (head0),
    .full    (full0),
    .empty   (empty0)
  );

  rsa_sync_fifo #(
    .RSA_DW     (RSA_DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .sys_rst (sys_rst),
    .flush   (flush),
    .wr_en   (push1),
    .wr_data (din_1),
    .rd_en   (pop1),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1)
  );

  // Round-robin pointer points away from the lane just served.
  always_ff @(posedge clk) begin
    if (sys_rst || !en) begin
      rr <= LANE0;
    end else if (mode && load) begin
      rr <= ~gnt.lane;
    end
  end

  // Output register: load on grant, drop valid when drained.
  always_ff @(posedge clk) begin
    if (sys_rst || !en) begin
      dout       <= '0;
      dout_src   <= LANE0;
      dout_valid <= 1'b0;
    end else if (load_ok) begin
      if (gnt.vld) begin
        dout       <= (gnt.lane == LANE1) ? head1 : head0;
        dout_src   <= gnt.lane;
        dout_valid <= 1'b1;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regmux_merge2.sv
// Random-stimulus bench for regmux_merge2.
// Queue-based lane model feeds an output scoreboard.
module tb_regmux_merge2;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          en = 1'b1;
  logic          mode = 1'b0;
  logic          sel = 1'b0;
  logic [DW-1:0] din_0 = '0;
  logic          din_0_valid = 1'b0;
  logic          din_0_ready;
  logic [DW-1:0] din_1 = '0;
  logic          din_1_valid = 1'b0;
  logic          din_1_ready;
  logic [DW-1:0] dout;
  logic          dout_src;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  regmux_merge2 #(
    .RSA_DW     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .en          (en),
    .mode        (mode),
    .sel         (sel),
    .din_0       (din_0),
    .din_0_valid (din_0_valid),
    .din_0_ready (din_0_ready),
    .din_1       (din_1),
    .din_1_valid (din_1_valid),
    .din_1_ready (din_1_ready),
    .dout        (dout),
    .dout_src    (dout_src),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW:0]   sb[$];
  bit            rr_m = 1'b0;
  bit            mo_v = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h t=%0t",
                  nm, act, exp, $time);
  endtask

  task automatic step(input bit r, input bit e, input bit m,
                      input bit s, input bit v0, input bit v1,
                      input bit dr);
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    bit            er0;
    bit            er1;
    bit            ne0;
    bit            ne1;
    bit            gv;
    bit            g;
    logic [DW-1:0] w;
    d0 = DW'($urandom);
    d1 = DW'($urandom);
    @(negedge clk);
    sys_rst = r; en = e; mode = m; sel = s;
    din_0 = d0; din_0_valid = v0;
    din_1 = d1; din_1_valid = v1;
    dout_ready = dr;
    #1;
    er0 = !r && e && (q0.size() < DEPTH);
    er1 = !r && e && (q1.size() < DEPTH);
    chk(din_0_ready === er0, "din_0_ready",
        32'(din_0_ready), 32'(er0));
    chk(din_1_ready === er1, "din_1_ready",
        32'(din_1_ready), 32'(er1));
    #2;
    if (r || !e) begin
      q0.delete(); q1.delete(); sb.delete();
      rr_m = 1'b0; mo_v = 1'b0;
    end else begin
      ne0 = q0.size() != 0;
      ne1 = q1.size() != 0;
      if (!mo_v || dr) begin
        if (!m) begin
          g = s; gv = s ? ne1 : ne0;
        end else begin
          gv = ne0 || ne1;
          g  = (ne0 && ne1) ? rr_m : ne1;
        end
        if (gv) begin
          w = g ? q1.pop_front() : q0.pop_front();
          sb.push_back({g, w});
          mo_v = 1'b1;
          if (m) rr_m = !g;
        end else begin
          mo_v = 1'b0;
        end
      end
      if (v0 && er0) q0.push_back(d0);
      if (v1 && er1) q1.push_back(d1);
    end
  endtask

  // Monitor: compare presented word, retire it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk(dout_valid === mo_v, "dout_valid",
          32'(dout_valid), 32'(mo_v));
      if (dout_valid && !sys_rst && en) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_word", 32'(dout), 32'hffff_ffff);
        end else begin
          chk({dout_src, dout} === sb[0], "dout_word",
              32'({dout_src, dout}), 32'(sb[0]));
          if (dout_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit m;
    bit s;
    int pv0;
    int pv1;
    int pdr;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 1, 1);
    @(posedge clk);
    #1;
    chk(dout === '0, "reset_dout", 32'(dout), 32'h0);
    chk(!din_0_ready && !din_1_ready, "reset_ready",
        32'({din_0_ready, din_1_ready}), 32'h0);
    // directed: sel=1 keeps lane 0 parked, then sel=0 releases it
    step(0, 1, 0, 1, 1, 1, 1);
    step(0, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 1);
    // directed: preload both lanes, then round-robin drain
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 1);
    // directed: backpressure fills lane 0 then drains
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 0, 1);
    // directed: flush with words queued, then restart
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 1, 1, 1);
    // random phases
    for (int ph = 0; ph < 12; ph++) begin
      m   = ($urandom_range(0, 1) == 1);
      s   = ($urandom_range(0, 1) == 1);
      pv0 = $urandom_range(10, 100);
      pv1 = $urandom_range(10, 100);
      case (ph % 4)
        0:       pdr = 100;
        1:       pdr = 20;
        2:       pdr = 60;
        default: pdr = $urandom_range(0, 100);
      endcase
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 29) == 0) s = !s;
        if ($urandom_range(0, 49) == 0) m = !m;
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 119) != 0, m, s,
             $urandom_range(1, 100) <= pv0,
             $urandom_range(1, 100) <= pv1,
             $urandom_range(1, 100) <= pdr);
      end
    end
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 1);
    @(negedge clk);
    #4;
    chk(sb.size() == 0 && !dout_valid, "drain_empty",
        32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
